traffic_light_rr: RTL and testbench

//  Parametrised N-approach traffic-light controller; generalises the 2-street
//  (A/B) controller to N_DIR approaches with round-robin service.

---
 rtl/traffic_light_rr_pkg.sv | 28 ++
 rtl/traffic_light_rr_pick.sv | 40 ++++
 rtl/traffic_light_rr.sv | 168 ++++++++++++++++
 tb/tb_traffic_light_rr.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_rr_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_rr_pkg
// Shared definitions for the N-approach round-robin traffic-light controller.
//   phase_e  : phase encodings driven on the 'phase' output
//              (PH_GREEN=0, PH_YELLOW=1, PH_ALLRED=2)
//   idx_w    : width of an approach index for a given approach count
//   wrap_add : (base + k) modulo n, valid for 0 <= base,k < n
// -----------------------------------------------------------------------------
package traffic_light_rr_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    // A single approach still needs a 1-bit index, so clamp the $clog2 result.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_add(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/traffic_light_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder. Returns the first asserted request found
// searching base+1, base+2, ... base-1 (wrapping). The base position itself is
// never selected.
//   req_i   [N_DIR]  request vector
//   base_i  [IDX_W]  current owner; search starts just after it
//   idx_o   [IDX_W]  chosen approach (0 when nothing found)
//   found_o [1]      at least one request other than base_i
// -----------------------------------------------------------------------------
module rr_pick
    import traffic_light_rr_pkg::*;
#(
    parameter int N_DIR = 4,
    localparam int IDX_W = idx_w(N_DIR)
) (
    input  logic [N_DIR-1:0] req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset toward the nearest so that the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            cand = IDX_W'(wrap_add(int'(base_i), k, N_DIR));
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_rr.sv
// -----------------------------------------------------------------------------
// traffic_light_rr
// N-approach intersection controller with round-robin service, min/max green,
// programmable yellow and all-red clearance, and emergency preemption.
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-low
//   sensor        in   N_DIR  vehicle present per approach
//   preempt_valid in   1      emergency request
//   preempt_dir   in   IDX_W  approach to force green
//   green         out  N_DIR  green lamp per approach (registered)
//   yellow        out  N_DIR  yellow lamp per approach (registered)
//   red           out  N_DIR  red lamp per approach (registered)
//   cur_dir       out  IDX_W  approach owning the current phase
//   phase         out  2      PH_GREEN / PH_YELLOW / PH_ALLRED
// -----------------------------------------------------------------------------
module traffic_light_rr
    import traffic_light_rr_pkg::*;
#(
    parameter int N_DIR       = 4,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int CNT_W       = 8,
    localparam int IDX_W = idx_w(N_DIR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DIR-1:0] sensor,
    input  logic             preempt_valid,
    input  logic [IDX_W-1:0] preempt_dir,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] red,
    output logic [IDX_W-1:0] cur_dir,
    output logic [1:0]       phase
);

    // Timer thresholds are "duration minus one" because the timer reads 0 on
    // the first cycle of a phase.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'((T_ALL_RED > 0) ? (T_ALL_RED - 1) : 0);
    localparam logic [N_DIR-1:0] LANE0    = N_DIR'(1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] nxt_q, nxt_d;
    logic [N_DIR-1:0] green_q, green_d;
    logic [N_DIR-1:0] yellow_q, yellow_d;
    logic [N_DIR-1:0] red_q, red_d;

    logic [IDX_W-1:0] pick_idx;
    logic             other_req;
    logic             pre_ok;

    // The picker never returns the base lane, so 'found' is exactly
    // "some approach other than the current one is requesting".
    rr_pick #(
        .N_DIR (N_DIR)
    ) u_pick (
        .req_i   (sensor),
        .base_i  (cur_q),
        .idx_o   (pick_idx),
        .found_o (other_req)
    );

    // Out-of-range preemption targets are treated as no request at all.
    assign pre_ok = preempt_valid && (int'(preempt_dir) < N_DIR);

    // Next-state logic. Lamps are decoded from the *next* phase/owner so the
    // registered lamps line up with phase/cur_dir in the same cycle.
    always_comb begin
        phase_d = phase_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;

        unique case (phase_q)
            PH_GREEN: begin
                if (pre_ok && (preempt_dir != cur_q)) begin
                    phase_d = PH_YELLOW;
                    nxt_d   = preempt_dir;
                end else if (pre_ok) begin
                    phase_d = PH_GREEN;
                end else if (other_req && (timer_q >= MIN_LAST) &&
                             (!sensor[cur_q] || (timer_q >= MAX_LAST))) begin
                    phase_d = PH_YELLOW;
                    nxt_d   = pick_idx;
                end
            end
            PH_YELLOW: begin
                if (pre_ok) begin
                    nxt_d = preempt_dir;
                end
                if (timer_q >= YEL_LAST) begin
                    if (T_ALL_RED == 0) begin
                        phase_d = PH_GREEN;
                        cur_d   = nxt_d;
                    end else begin
                        phase_d = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (pre_ok) begin
                    nxt_d = preempt_dir;
                end
                if (timer_q >= AR_LAST) begin
                    phase_d = PH_GREEN;
                    cur_d   = nxt_d;
                end
            end
            default: begin
                phase_d = PH_GREEN;
            end
        endcase

        // Restart on any phase change, otherwise count up and stick at max.
        if (phase_d != phase_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + CNT_W'(1);
        end else begin
            timer_d = timer_q;
        end

        green_d  = '0;
        yellow_d = '0;
        red_d    = '1;
        if (phase_d == PH_GREEN) begin
            green_d[cur_d] = 1'b1;
            red_d[cur_d]   = 1'b0;
        end else if (phase_d == PH_YELLOW) begin
            yellow_d[cur_d] = 1'b1;
            red_d[cur_d]    = 1'b0;
        end
    end

    // State and lamp registers; reset drops straight back to lane 0 green.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_GREEN;
            timer_q  <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            green_q  <= LANE0;
            yellow_q <= '0;
            red_q    <= ~LANE0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    assign green   = green_q;
    assign yellow  = yellow_q;
    assign red     = red_q;
    assign cur_dir = cur_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_light_rr.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_rr
// Scoreboard bench: each stimulus cycle advances a duration-based reference
// model of the intersection and queues the lamp/phase picture expected after
// the next clock edge; an independent monitor pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_traffic_light_rr;

    localparam int N     = 4;
    localparam int MIN_G = 5;
    localparam int MAX_G = 20;
    localparam int YEL   = 3;
    localparam int ALLR  = 1;

    typedef struct {
        logic [N-1:0] green;
        logic [N-1:0] yellow;
        logic [N-1:0] red;
        logic [1:0]   cur;
        logic [1:0]   phase;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] sensor;
    logic         preempt_valid;
    logic [1:0]   preempt_dir;
    logic [N-1:0] green;
    logic [N-1:0] yellow;
    logic [N-1:0] red;
    logic [1:0]   cur_dir;
    logic [1:0]   phase;

    int   checks;
    int   errors;
    int   cyc;
    bit   monOn;
    exp_t expQ[$];
    exp_t monE;

    // Reference model: phase 0/1/2 = green/yellow/allred, mAge counts the
    // cycles already shown in the current phase (1 on the first cycle).
    int mPhase;
    int mCur;
    int mNxt;
    int mAge;

    traffic_light_rr dut (
        .clk           (clk),
        .reset         (reset),
        .sensor        (sensor),
        .preempt_valid (preempt_valid),
        .preempt_dir   (preempt_dir),
        .green         (green),
        .yellow        (yellow),
        .red           (red),
        .cur_dir       (cur_dir),
        .phase         (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return to the power-on picture: lane 0 green, fresh phase.
    task automatic modelReset();
        mPhase = 0;
        mCur   = 0;
        mNxt   = 0;
        mAge   = 1;
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.green  = '0;
        e.yellow = '0;
        e.red    = '1;
        e.cur    = 2'(mCur);
        e.phase  = 2'(mPhase);
        for (int i = 0; i < N; i++) begin
            if (i == mCur && mPhase == 0) begin
                e.green[i] = 1'b1;
                e.red[i]   = 1'b0;
            end
            if (i == mCur && mPhase == 1) begin
                e.yellow[i] = 1'b1;
                e.red[i]    = 1'b0;
            end
        end
        return e;
    endfunction

    // Advance the model by one clock given this cycle's inputs.
    task automatic modelStep(input logic [N-1:0] s, input bit pv, input int pd);
        bit pre;
        bit other;
        int first;
        pre   = pv && (pd < N);
        other = 1'b0;
        first = -1;
        for (int k = 1; k < N; k++) begin
            if (s[(mCur + k) % N]) begin
                other = 1'b1;
                if (first < 0) first = (mCur + k) % N;
            end
        end
        case (mPhase)
            0: begin
                if (pre && pd != mCur) begin
                    mNxt = pd; mPhase = 1; mAge = 1;
                end else if (pre) begin
                    mAge++;
                end else if (other && mAge >= MIN_G && (!s[mCur] || mAge >= MAX_G)) begin
                    mNxt = first; mPhase = 1; mAge = 1;
                end else begin
                    mAge++;
                end
            end
            1: begin
                if (pre) mNxt = pd;
                if (mAge >= YEL) begin
                    if (ALLR == 0) begin
                        mPhase = 0; mCur = mNxt;
                    end else begin
                        mPhase = 2;
                    end
                    mAge = 1;
                end else begin
                    mAge++;
                end
            end
            default: begin
                if (pre) mNxt = pd;
                if (mAge >= ALLR) begin
                    mPhase = 0; mCur = mNxt; mAge = 1;
                end else begin
                    mAge++;
                end
            end
        endcase
    endtask

    // Called at a falling edge: drive inputs, predict, queue, wait one cycle.
    task automatic applyStimulus(input logic [N-1:0] s, input bit pv, input int pd);
        sensor        = s;
        preempt_valid = pv;
        preempt_dir   = 2'(pd);
        modelStep(s, pv, pd);
        expQ.push_back(modelOut());
        @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        checks += 5;
        if (green !== e.green) begin
            errors++;
            $display("[TB] FAIL %s green got %b want %b", tag, green, e.green);
        end
        if (yellow !== e.yellow) begin
            errors++;
            $display("[TB] FAIL %s yellow got %b want %b", tag, yellow, e.yellow);
        end
        if (red !== e.red) begin
            errors++;
            $display("[TB] FAIL %s red got %b want %b", tag, red, e.red);
        end
        if (cur_dir !== e.cur) begin
            errors++;
            $display("[TB] FAIL %s cur_dir got %0d want %0d", tag, cur_dir, e.cur);
        end
        if (phase !== e.phase) begin
            errors++;
            $display("[TB] FAIL %s phase got %0d want %0d", tag, phase, e.phase);
        end
    endtask

    function automatic exp_t resetPicture();
        exp_t e;
        e.green  = 4'b0001;
        e.yellow = 4'b0000;
        e.red    = 4'b1110;
        e.cur    = 2'd0;
        e.phase  = 2'd0;
        return e;
    endfunction

    // Entered at a falling edge with the scoreboard drained; asserts reset
    // between edges so the lamps must change without any clock.
    task automatic doReset();
        monOn = 1'b0;
        #2 reset = 1'b0;
        #1 checkOutput(resetPicture(), "asyncReset");
        @(negedge clk);
        checkOutput(resetPicture(), "resetHold");
        reset = 1'b1;
        modelReset();
        monOn = 1'b1;
    endtask

    // Monitor: one queued expectation per clock while the bench is tracking.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (monOn && reset) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboardEmpty cyc%0d got 0 entries want 1", cyc);
            end else begin
                monE = expQ.pop_front();
                checkOutput(monE, $sformatf("cyc%0d", cyc));
            end
        end
    end

    initial begin
        logic [N-1:0] rs;
        int pcnt;
        int ppd;
        bit pvr;
        checks = 0;
        errors = 0;
        cyc    = 0;
        monOn  = 1'b0;
        reset  = 1'b0;
        sensor = '0;
        preempt_valid = 1'b0;
        preempt_dir   = '0;

        #7 checkOutput(resetPicture(), "resetInit");
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        monOn = 1'b1;

        // No traffic: lane 0 keeps green forever.
        repeat (60) applyStimulus(4'b0000, 1'b0, 0);

        // Single waiting lane 2: min green, yellow, all-red, then lane 2.
        doReset();
        repeat (40) applyStimulus(4'b0100, 1'b0, 0);

        // Preempt to lane 2 two cycles into green, held with competing traffic.
        doReset();
        repeat (2) applyStimulus(4'b0000, 1'b0, 0);
        repeat (30) applyStimulus(4'b1011, 1'b1, 2);
        repeat (40) applyStimulus(4'b1011, 1'b0, 0);

        // Alternating requesters only.
        doReset();
        repeat (100) applyStimulus(4'b1010, 1'b0, 0);

        // Saturated intersection.
        doReset();
        repeat (110) applyStimulus(4'b1111, 1'b0, 0);

        // Random traffic with occasional preemption and one reset mid-yellow.
        rs   = 4'b0000;
        pcnt = 0;
        ppd  = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       rs = 4'b0000;
                    1:       rs = 4'b0100;
                    2:       rs = 4'b1111;
                    3:       rs = 4'b1010;
                    default: rs = 4'($urandom);
                endcase
            end
            if (pcnt == 0) begin
                pvr = 1'b0;
                if ($urandom_range(0, 49) == 0) begin
                    pcnt = $urandom_range(3, 40);
                    ppd  = $urandom_range(0, 3);
                end
            end else begin
                pvr = 1'b1;
                pcnt--;
            end
            if (c == 1200) begin
                for (int w = 0; w < 60 && mPhase != 1; w++) begin
                    applyStimulus(4'b0110, 1'b0, 0);
                end
                doReset();
            end
            applyStimulus(rs, pvr, ppd);
        end

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d entries want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
